// File: rtl/key_step_counter.sv
// rtl/key_step_counter.sv - debounced up/down pushbutton stepper feeding the display value
// Optional hold-to-repeat stepping is built only when KSC_AUTOREPEAT_EN is defined.
module key_step_counter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_VAL         = 15,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       RST,
    input  logic [1:0] KEY,
    output logic [3:0] V,
    output logic       V_VALID,
    output logic       WRAP
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] V_MAX = 4'(MAX_VAL);

    generate
        if (DEBOUNCE_CYCLES < 2 || MAX_VAL < 1 || MAX_VAL > 15 ||
            REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
            $error("key_step_counter: illegal parameter value");
        end
    endgenerate

    logic [1:0]    sync1, sync2, stable, stable_d, evt, press, rpt;
    logic [CW-1:0] db_cnt [2];

    assign press = stable_d & ~stable;

    // Bounces shorter than DEBOUNCE_CYCLES restart the count, so only a level held long enough is accepted.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (RST) begin
            sync1     <= 2'b11;
            sync2     <= 2'b11;
            stable    <= 2'b11;
            stable_d  <= 2'b11;
            evt       <= 2'b00;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1    <= KEY;
            sync2    <= sync1;
            stable_d <= stable;
            evt      <= press | rpt;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == stable[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    stable[k] <= ~stable[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

`ifdef KSC_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);

    logic [RW-1:0] hold_cnt [2];
    logic [1:0]    armed, repeating, other_rel;

    assign other_rel = {stable[0], stable[1]};

    always_comb begin
        rpt = 2'b00;
        for (int k = 0; k < 2; k++) begin
            rpt[k] = armed[k] & ~stable[k] & other_rel[k] &
                     (hold_cnt[k] == (repeating[k] ? R_PERIOD : R_DELAY));
        end
    end

    // Counting restarts at 1 on the press and after each repeat so the next match lands exactly on time.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (RST) begin
            armed       <= 2'b00;
            repeating   <= 2'b00;
            hold_cnt[0] <= '0;
            hold_cnt[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (press[k]) begin
                    armed[k]     <= 1'b1;
                    repeating[k] <= 1'b0;
                    hold_cnt[k]  <= RW'(1);
                end else if (armed[k] && !stable[k] && other_rel[k]) begin
                    if (rpt[k]) begin
                        repeating[k] <= 1'b1;
                        hold_cnt[k]  <= RW'(1);
                    end else begin
                        hold_cnt[k] <= hold_cnt[k] + 1'b1;
                    end
                end else begin
                    armed[k]     <= 1'b0;
                    repeating[k] <= 1'b0;
                    hold_cnt[k]  <= '0;
                end
            end
        end
    end
`else
    assign rpt = 2'b00;
`endif

    always_ff @(posedge MAX10_CLK1_50) begin
        if (RST) begin
            V       <= 4'd0;
            V_VALID <= 1'b0;
            WRAP    <= 1'b0;
        end else begin
            V_VALID <= 1'b0;
            WRAP    <= 1'b0;
            if (evt[0] && !evt[1]) begin
                V_VALID <= 1'b1;
                if (V == V_MAX) begin
                    V    <= 4'd0;
                    WRAP <= 1'b1;
                end else begin
                    V <= V + 1'b1;
                end
            end else if (evt[1] && !evt[0]) begin
                V_VALID <= 1'b1;
                if (V == 4'd0) begin
                    V    <= V_MAX;
                    WRAP <= 1'b1;
                end else begin
                    V <= V - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_step_counter.sv
// tb/tb_key_step_counter.sv - randomized and directed bench for key_step_counter against a cycle model
module tb_key_step_counter;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

`ifdef KSC_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key;
    logic [3:0] v_a, v_b;
    logic       vv_a, vv_b, w_a, w_b;

    always #5 clk = ~clk;

    key_step_counter #(.DEBOUNCE_CYCLES(D), .MAX_VAL(15), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_a (
        .MAX10_CLK1_50(clk), .RST(rst), .KEY(key), .V(v_a), .V_VALID(vv_a), .WRAP(w_a)
    );
    key_step_counter #(.DEBOUNCE_CYCLES(D), .MAX_VAL(9), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_b (
        .MAX10_CLK1_50(clk), .RST(rst), .KEY(key), .V(v_b), .V_VALID(vv_b), .WRAP(w_b)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: raw key samples, accepted levels, pending step events.
    int         edge_n = 0;
    bit         hist [2][0:D+1];
    bit         stable_m [2];
    bit         ev_next [2];
    bit         ev_reg [2];
    bit         held_ok [2];
    int         pe [2];
    int         maxv [2] = '{15, 9};
    logic [3:0] exp_v [2];
    bit         exp_vv [2];
    bit         exp_w [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i <= D + 1; i++) hist[k][i] = 1'b1;
            stable_m[k] = 1'b1;
            ev_next[k]  = 1'b0;
            ev_reg[k]   = 1'b0;
            held_ok[k]  = 1'b0;
            pe[k]       = 0;
            exp_v[k]    = 4'd0;
            exp_vv[k]   = 1'b0;
            exp_w[k]    = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [1:0] k_in, input logic r);
        bit up, dn, rep, flip;
        bit nreg [2];
        int age, t;
        edge_n++;
        if (r) begin
            model_reset();
            return;
        end
        up = ev_reg[0];
        dn = ev_reg[1];
        for (int m = 0; m < 2; m++) begin
            exp_vv[m] = 1'b0;
            exp_w[m]  = 1'b0;
            if (up != dn) begin
                exp_vv[m] = 1'b1;
                if (up) begin
                    exp_w[m] = (int'(exp_v[m]) == maxv[m]);
                    t = (int'(exp_v[m]) + 1) % (maxv[m] + 1);
                end else begin
                    exp_w[m] = (exp_v[m] == 4'd0);
                    t = (int'(exp_v[m]) + maxv[m]) % (maxv[m] + 1);
                end
                exp_v[m] = t[3:0];
            end
        end
        for (int k = 0; k < 2; k++) begin
            rep = 1'b0;
            if (ev_next[k]) begin
                pe[k]      = edge_n;
                held_ok[k] = 1'b1;
            end else if (held_ok[k]) begin
                if (AUTOREP && !stable_m[k] && stable_m[1-k]) begin
                    age = edge_n - pe[k];
                    rep = (age >= RD) && ((age - RD) % RP == 0);
                end else begin
                    held_ok[k] = 1'b0;
                end
            end
            nreg[k] = ev_next[k] | rep;
        end
        for (int k = 0; k < 2; k++) begin
            ev_reg[k] = nreg[k];
            for (int i = 0; i <= D; i++) hist[k][i] = hist[k][i+1];
            hist[k][D+1] = k_in[k];
            flip = 1'b1;
            for (int i = 0; i < D; i++) if (hist[k][i] == stable_m[k]) flip = 1'b0;
            ev_next[k] = flip && stable_m[k];
            if (flip) stable_m[k] = ~stable_m[k];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(key, rst);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key = 2'b11;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst = 1'b0;
            tick();
            n_vec++;
            if ({v_a, vv_a, w_a, v_b, vv_b, w_b} !== 12'd0) begin
                n_err++;
                $display("FAIL reset cyc %0d: a=%0d/%b/%b b=%0d/%b/%b expected all zero", i, v_a, vv_a, w_a, v_b, vv_b, w_b);
            end
        end
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        for (int i = 0; i < 24; i++) begin
            key[0] = (i < 12) ? 1'b0 : 1'b1;
            tick();
            pulses += int'(vv_a);
            n_vec++;
            if ({v_a, vv_a, w_a, v_b, vv_b, w_b} !== {exp_v[0], exp_vv[0], exp_w[0], exp_v[1], exp_vv[1], exp_w[1]}) begin
                n_err++;
                $display("FAIL clean_press cyc %0d: a=%0d/%b/%b b=%0d/%b/%b expected a=%0d/%b/%b b=%0d/%b/%b", i,
                         v_a, vv_a, w_a, v_b, vv_b, w_b, exp_v[0], exp_vv[0], exp_w[0], exp_v[1], exp_vv[1], exp_w[1]);
            end
            if (i == 2 + D) begin
                n_vec++;
                if (v_a !== 4'd0 || vv_a !== 1'b0) begin
                    n_err++;
                    $display("FAIL clean_press_early: v=%0d vv=%b expected v=0 vv=0", v_a, vv_a);
                end
            end
            if (i == 2 + D + 1) begin
                n_vec++;
                if (v_a !== 4'd1 || vv_a !== 1'b1 || w_a !== 1'b0) begin
                    n_err++;
                    $display("FAIL clean_press_latency: v=%0d vv=%b w=%b expected v=1 vv=1 w=0", v_a, vv_a, w_a);
                end
            end
        end
        n_vec++;
        if (pulses != 1 || v_a !== 4'd1) begin
            n_err++;
            $display("FAIL clean_press_count: pulses=%0d v=%0d expected pulses=1 v=1", pulses, v_a);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int i = 0; i < 36; i++) begin
            key[0] = (i < 24) ? (((i / 2) % 2) == 1) : 1'b1;
            tick();
            pulses += int'(vv_a) + int'(vv_b);
            n_vec++;
            if ({v_a, vv_a, w_a, v_b, vv_b, w_b} !== {exp_v[0], exp_vv[0], exp_w[0], exp_v[1], exp_vv[1], exp_w[1]}) begin
                n_err++;
                $display("FAIL bounce cyc %0d: a=%0d/%b/%b b=%0d/%b/%b expected a=%0d/%b/%b b=%0d/%b/%b", i,
                         v_a, vv_a, w_a, v_b, vv_b, w_b, exp_v[0], exp_vv[0], exp_w[0], exp_v[1], exp_vv[1], exp_w[1]);
            end
        end
        n_vec++;
        if (pulses != 0 || v_a !== 4'd1) begin
            n_err++;
            $display("FAIL bounce_ignored: pulses=%0d v=%0d expected pulses=0 v=1", pulses, v_a);
        end
    endtask

    task automatic test_wrap();
        int wraps_a = 0;
        int wraps_b = 0;
        int seq [4] = '{1, 1, 0, 1};
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 18; i++) begin
                key = 2'b11;
                if (i < 8) key[seq[p]] = 1'b0;
                tick();
                wraps_a += int'(w_a);
                wraps_b += int'(w_b);
                n_vec++;
                if ({v_a, vv_a, w_a, v_b, vv_b, w_b} !== {exp_v[0], exp_vv[0], exp_w[0], exp_v[1], exp_vv[1], exp_w[1]}) begin
                    n_err++;
                    $display("FAIL wrap p%0d cyc %0d: a=%0d/%b/%b b=%0d/%b/%b expected a=%0d/%b/%b b=%0d/%b/%b", p, i,
                             v_a, vv_a, w_a, v_b, vv_b, w_b, exp_v[0], exp_vv[0], exp_w[0], exp_v[1], exp_vv[1], exp_w[1]);
                end
            end
        end
        n_vec++;
        if (wraps_a != 3 || wraps_b != 3 || v_a !== 4'd15 || v_b !== 4'd9) begin
            n_err++;
            $display("FAIL wrap_summary: wraps=%0d/%0d v=%0d/%0d expected wraps=3/3 v=15/9", wraps_a, wraps_b, v_a, v_b);
        end
    endtask

    task automatic test_simultaneous();
        int pulses = 0;
        for (int i = 0; i < 22; i++) begin
            key = (i < 10) ? 2'b00 : 2'b11;
            tick();
            pulses += int'(vv_a) + int'(w_a) + int'(vv_b) + int'(w_b);
            n_vec++;
            if ({v_a, vv_a, w_a, v_b, vv_b, w_b} !== {exp_v[0], exp_vv[0], exp_w[0], exp_v[1], exp_vv[1], exp_w[1]}) begin
                n_err++;
                $display("FAIL simultaneous cyc %0d: a=%0d/%b/%b b=%0d/%b/%b expected a=%0d/%b/%b b=%0d/%b/%b", i,
                         v_a, vv_a, w_a, v_b, vv_b, w_b, exp_v[0], exp_vv[0], exp_w[0], exp_v[1], exp_vv[1], exp_w[1]);
            end
        end
        n_vec++;
        if (pulses != 0 || v_a !== 4'd15 || v_b !== 4'd9) begin
            n_err++;
            $display("FAIL simultaneous_nostep: pulses=%0d v=%0d/%0d expected pulses=0 v=15/9", pulses, v_a, v_b);
        end
    endtask

    task automatic test_autorepeat();
        localparam int LOW = 58;
        int got [$];
        int want [$];
        int s;
        rst = 1'b1;
        key = 2'b11;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < LOW + 16; i++) begin
            key[0] = (i < LOW) ? 1'b0 : 1'b1;
            tick();
            if (vv_a) got.push_back(i);
            n_vec++;
            if ({v_a, vv_a, w_a, v_b, vv_b, w_b} !== {exp_v[0], exp_vv[0], exp_w[0], exp_v[1], exp_vv[1], exp_w[1]}) begin
                n_err++;
                $display("FAIL autorepeat cyc %0d: a=%0d/%b/%b b=%0d/%b/%b expected a=%0d/%b/%b b=%0d/%b/%b", i,
                         v_a, vv_a, w_a, v_b, vv_b, w_b, exp_v[0], exp_vv[0], exp_w[0], exp_v[1], exp_vv[1], exp_w[1]);
            end
        end
        // Steps land at press+0, +RD, +RD+RP ... while the accepted level is still low one edge earlier.
        s = 2 + D + 1;
        want.push_back(s);
        if (AUTOREP) begin
            s += RD;
            while (s - 1 <= LOW + D + 1) begin
                want.push_back(s);
                s += RP;
            end
        end
        n_vec++;
        if (got.size() != want.size() || int'(v_a) != want.size() || int'(v_b) != want.size()) begin
            n_err++;
            $display("FAIL autorepeat_count: steps=%0d v=%0d/%0d expected steps=%0d", got.size(), v_a, v_b, want.size());
        end
        for (int j = 0; j < want.size() && j < got.size(); j++) begin
            n_vec++;
            if (got[j] != want[j]) begin
                n_err++;
                $display("FAIL autorepeat_step%0d: cycle=%0d expected cycle=%0d", j, got[j], want[j]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int b = 0; b < 2; b++) if ($urandom_range(0, 7) == 0) key[b] = ~key[b];
            if (i >= 588) begin
                rst = 1'b0;
                key = 2'b11;
            end
            tick();
            n_vec++;
            if ({v_a, vv_a, w_a, v_b, vv_b, w_b} !== {exp_v[0], exp_vv[0], exp_w[0], exp_v[1], exp_vv[1], exp_w[1]}) begin
                n_err++;
                $display("FAIL random cyc %0d key=%b rst=%b: a=%0d/%b/%b b=%0d/%b/%b expected a=%0d/%b/%b b=%0d/%b/%b", i, key, rst,
                         v_a, vv_a, w_a, v_b, vv_b, w_b, exp_v[0], exp_vv[0], exp_w[0], exp_v[1], exp_vv[1], exp_w[1]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        key = 2'b11;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrap();
        test_simultaneous();
        test_autorepeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
